// File: rtl/babbage_engine_param.sv
// babbage_engine_param
// Difference-engine polynomial evaluator of parameterised order. Loads
// ORDER+1 seed samples f(0)..f(ORDER), folds them into a forward-difference
// table in ORDER cycles, then streams f(0)..f(count-1) using only additions.
// All arithmetic wraps modulo 2^W. Output stream honours valid/ready.
module babbage_engine_param #(
    parameter int W     = 32,
    parameter int ORDER = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_index,
    output logic             ready,
    output logic             done_tick
);

    // Load index and precalc level both range over 0..ORDER.
    localparam int IDX_W = (ORDER < 2) ? 1 : $clog2(ORDER + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ORDER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRECALC,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_d [ORDER+1];
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_lvl;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_done_tick;

    logic w_in_fire;
    logic w_out_fire;
    logic w_last_out;

    assign w_in_fire  = r_in_ready & in_valid;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_last_out = (r_n == r_count - CNT_W'(1));

    assign ready     = r_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign done_tick = r_done_tick;
    assign out_data  = r_d[0];
    assign out_index = r_n;

    // Control FSM and difference table; status flags are registered alongside
    // the state so each one is a pure function of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            // NOTE: the table is reset like any other flop because d[0] is
            // visible on out_data straight out of reset.
            for (int i = 0; i <= ORDER; i++) begin
                r_d[i] <= '0;
            end
            r_idx       <= '0;
            r_lvl       <= '0;
            r_n         <= '0;
            r_count     <= '0;
            r_ready     <= 1'b1;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_done_tick <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count    <= count;
                        r_idx      <= '0;
                        r_state    <= S_LOAD;
                        r_ready    <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (w_in_fire) begin
                        for (int i = 0; i <= ORDER; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_d[i] <= in_data;
                            end
                        end
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == LAST) begin
                            r_lvl      <= IDX_W'(1);
                            r_state    <= S_PRECALC;
                            r_in_ready <= 1'b0;
                        end
                    end
                end

                S_PRECALC: begin
                    // NOTE: non-blocking updates make every d[i-1] below read
                    // the pre-edge table, which is exactly the parallel
                    // difference step; blocking here would cascade levels.
                    for (int i = 1; i <= ORDER; i++) begin
                        if (IDX_W'(i) >= r_lvl) begin
                            r_d[i] <= r_d[i] - r_d[i-1];
                        end
                    end
                    if (r_lvl == LAST) begin
                        r_n <= '0;
                        if (r_count == '0) begin
                            r_state     <= S_DONE;
                            r_done_tick <= 1'b1;
                        end else begin
                            r_state     <= S_CALC;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_lvl <= r_lvl + IDX_W'(1);
                    end
                end

                S_CALC: begin
                    if (w_out_fire) begin
                        for (int i = 0; i < ORDER; i++) begin
                            r_d[i] <= r_d[i] + r_d[i+1];
                        end
                        r_n <= r_n + CNT_W'(1);
                        if (w_last_out) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b0;
                            r_done_tick <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done_tick <= 1'b0;
                    r_ready     <= 1'b1;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done_tick <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_babbage_engine_param.sv
// Testbench for babbage_engine_param. Expected samples come from Newton's
// forward-difference formula f(n) = sum_i C(n,i) * delta^i f(0), evaluated
// with plain integer arithmetic and reduced modulo 2^W.
module tb_babbage_engine_param;

    localparam int W     = 32;
    localparam int K     = 3;
    localparam int CNT_W = 16;
    localparam int TMO   = 3000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] out_index;
    logic             ready;
    logic             done_tick;

    // Narrow, second-order instance for wrap-around behaviour.
    logic             start8 = 1'b0;
    logic [CNT_W-1:0] count8 = '0;
    logic             in_valid8 = 1'b0;
    logic [7:0]       in_data8 = '0;
    logic             in_ready8;
    logic             out_valid8;
    logic             out_ready8 = 1'b0;
    logic [7:0]       out_data8;
    logic [CNT_W-1:0] out_index8;
    logic             ready8;
    logic             done_tick8;

    babbage_engine_param #(.W(W), .ORDER(K), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .ready     (ready),
        .done_tick (done_tick)
    );

    babbage_engine_param #(.W(8), .ORDER(2), .CNT_W(CNT_W)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .count     (count8),
        .in_valid  (in_valid8),
        .in_data   (in_data8),
        .in_ready  (in_ready8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_index (out_index8),
        .ready     (ready8),
        .done_tick (done_tick8)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    longint seeds[9];
    int     job_count = 0;
    int     exp_n = 0;
    bit     chk_en = 1'b0;
    int     done_seen = 0;
    int     edge_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint binom(input longint n, input int k);
        longint r;
        r = 1;
        if (k > n) return 0;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // f(n) from the seed samples via Newton's forward-difference series.
    function automatic logic [63:0] model_f(input longint n, input int k,
                                            input longint s[9], input int w);
        longint acc;
        longint d;
        logic [63:0] mask;
        acc = 0;
        for (int i = 0; i <= k; i++) begin
            d = 0;
            for (int j = 0; j <= i; j++) begin
                if (((i - j) % 2) != 0) d -= binom(i, j) * s[j];
                else                    d += binom(i, j) * s[j];
            end
            acc += binom(n, i) * d;
        end
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return 64'(acc) & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // Scoreboard: every cycle the stream is valid, index and data must match
    // the next expected sample; a handshake advances the expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            if (out_valid) begin
                check("out_index", 64'(out_index), 64'(exp_n));
                check("out_data", 64'(out_data), model_f(exp_n, K, seeds, W));
                if (out_ready) exp_n++;
            end
            if (done_tick) begin
                check("outputs_before_done", 64'(exp_n), 64'(job_count));
                done_seen++;
            end
        end
    end

    // One job on the main instance. rmode: 0 always ready, 1 pattern 1,0,0,
    // 2 random. abort_at >= 0 pulls reset when that index is presented.
    task automatic run_job(input int cnt, input int rmode, input bit gaps,
                           input bit poke_start, input int abort_at);
        int budget;
        int ld;
        int phase;
        bit acc;
        budget = 0;
        while (!ready && budget < TMO) begin
            tick();
            budget++;
        end
        check("ready_before_start", 64'(ready), 64'd1);
        job_count = cnt;
        exp_n     = 0;
        done_seen = 0;
        chk_en    = 1'b1;
        start     = 1'b1;
        count     = CNT_W'(cnt);
        edge_cnt  = 0;
        tick();
        start = 1'b0;
        count = '0;

        ld = 0;
        budget = 0;
        while (ld <= K && budget < TMO) begin
            in_data  = W'(seeds[ld]);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) ld++;
            budget++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("seeds_accepted", 64'(ld), 64'(K + 1));

        budget = 0;
        while (!out_valid && !done_tick && budget < TMO) begin
            tick();
            budget++;
        end
        if (!gaps) check("start_to_first_result", 64'(edge_cnt), 64'(2 * K + 2));
        if (cnt == 0) begin
            check("zero_count_no_valid", 64'(out_valid), 64'd0);
            check("zero_count_done", 64'(done_tick), 64'd1);
        end

        phase = 0;
        budget = 0;
        while (!done_tick && budget < TMO) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((phase % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke_start && (phase == 2);
            count = (poke_start && (phase == 2)) ? CNT_W'(3) : '0;
            phase++;
            if (abort_at >= 0 && out_valid && out_index == CNT_W'(abort_at)) begin
                chk_en = 1'b0;
                start  = 1'b0;
                #2;
                reset = 1'b0;
                #1;
                check("abort_ready", 64'(ready), 64'd1);
                check("abort_in_ready", 64'(in_ready), 64'd0);
                check("abort_out_valid", 64'(out_valid), 64'd0);
                check("abort_out_data", 64'(out_data), 64'd0);
                check("abort_out_index", 64'(out_index), 64'd0);
                check("abort_done_tick", 64'(done_tick), 64'd0);
                @(negedge clk);
                reset     = 1'b1;
                out_ready = 1'b0;
                return;
            end
            tick();
            budget++;
        end
        start = 1'b0;
        check("done_tick_seen", 64'(done_tick), 64'd1);
        out_ready = 1'b0;
        tick();
        check("done_tick_one_cycle", 64'(done_tick), 64'd0);
        check("ready_after_done", 64'(ready), 64'd1);
        check("done_pulse_count", 64'(done_seen), 64'd1);
        chk_en = 1'b0;
    endtask

    // Second-order, 8-bit job: squares wrap past 255.
    task automatic run_w8();
        longint s8[9];
        logic [7:0] got[20];
        int ng;
        int ld;
        int budget;
        bit acc;
        s8 = '{0, 1, 4, 0, 0, 0, 0, 0, 0};
        ng = 0;
        for (int i = 0; i < 20; i++) got[i] = '0;
        start8 = 1'b1;
        count8 = CNT_W'(20);
        tick();
        start8 = 1'b0;
        ld = 0;
        budget = 0;
        while (ld < 3 && budget < TMO) begin
            in_data8  = 8'(s8[ld]);
            in_valid8 = 1'b1;
            @(negedge clk);
            acc = in_ready8;
            tick();
            if (acc) ld++;
            budget++;
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        budget = 0;
        while (!done_tick8 && budget < TMO) begin
            @(negedge clk);
            if (out_valid8 && ng < 20) begin
                check("w8_index", 64'(out_index8), 64'(ng));
                got[ng] = out_data8;
                ng++;
            end
            tick();
            budget++;
        end
        out_ready8 = 1'b0;
        check("w8_done", 64'(done_tick8), 64'd1);
        check("w8_output_count", 64'(ng), 64'd20);
        check("w8_f4", 64'(got[4]), 64'd16);
        check("w8_f15", 64'(got[15]), 64'd225);
        check("w8_f16_wrap", 64'(got[16]), 64'd0);
        check("w8_f17_wrap", 64'(got[17]), 64'd33);
        for (int i = 0; i < 20; i++) check("w8_model", 64'(got[i]), model_f(i, 2, s8, 8));
    endtask

    initial begin
        for (int i = 0; i < 9; i++) seeds[i] = 0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_index", 64'(out_index), 64'd0);
        check("reset_done_tick", 64'(done_tick), 64'd0);
        reset = 1'b1;
        tick();

        // Cubes: 0,1,8,27,64,125 with the 8-edge start-to-result latency.
        seeds = '{0, 1, 8, 27, 0, 0, 0, 0, 0};
        check("model_cube5", model_f(5, K, seeds, W), 64'd125);
        run_job(6, 0, 1'b0, 1'b0, -1);

        // Squares (third difference zero): plain, then stalled with gapped load.
        seeds = '{0, 1, 4, 9, 0, 0, 0, 0, 0};
        check("model_square4", model_f(4, K, seeds, W), 64'd16);
        run_job(5, 0, 1'b0, 1'b0, -1);
        run_job(5, 1, 1'b1, 1'b0, -1);

        // Empty job, then start pulsed mid-stream.
        run_job(0, 0, 1'b0, 1'b0, -1);
        seeds = '{0, 1, 8, 27, 0, 0, 0, 0, 0};
        run_job(12, 0, 1'b0, 1'b1, -1);

        // Reset while index 3 is presented, then a clean job.
        run_job(10, 0, 1'b0, 1'b0, 3);
        seeds = '{5, 3, 7, 2, 0, 0, 0, 0, 0};
        run_job(8, 2, 1'b0, 1'b0, -1);

        run_w8();

        // Random seeds (full-width, so differences are often negative).
        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j <= K; j++) seeds[j] = longint'($urandom);
            run_job(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
